adc_capture_buf: RTL

Triggered snapshot buffer sitting directly downstream of the ADC AXI4-Stream slave ports (adc20axis/adc21axis) exported by the PL top. It accepts ADC sample beats and, after being armed and triggered, writes a programmed number of beats into a to-host BRAM port for readout over the local bus. Optional decimation keeps one beat in N. One instance per ADC stream.

---
 rtl/adc_capture_buf_if.sv | 23 ++
 rtl/adc_capture_buf.sv | 113 +++++++++++
 2 files changed

// File: rtl/adc_capture_buf_if.sv
// Stream-in / BRAM-write bundle for adc_capture_buf.
// slave is the capture buffer's side; master is the upstream/readout side.
interface adc_capture_buf_if #(
    parameter int unsigned ADC_AXIS_DATAWIDTH   = 128,
    parameter int unsigned BRAMTOHOST_ADDRWIDTH = 13
);
    logic [ADC_AXIS_DATAWIDTH-1:0]   s_tdata;
    logic                            s_tvalid;
    logic                            s_tready;
    logic [BRAMTOHOST_ADDRWIDTH-1:0] bram_addr;
    logic [ADC_AXIS_DATAWIDTH-1:0]   bram_data;
    logic                            bram_we;

    modport slave (
        input  s_tdata, s_tvalid,
        output s_tready, bram_addr, bram_data, bram_we
    );

    modport master (
        output s_tdata, s_tvalid,
        input  s_tready, bram_addr, bram_data, bram_we
    );
endinterface

// File: rtl/adc_capture_buf.sv
// Armed/triggered ADC snapshot buffer writing a programmed number of beats to BRAM.
// Optional keep-one-in-N decimation when ADC_CAPTURE_DECIM_EN is defined.
module adc_capture_buf #(
    parameter int unsigned ADC_AXIS_DATAWIDTH   = 128,
    parameter int unsigned BRAMTOHOST_ADDRWIDTH = 13
) (
    input  logic                            dspclk,
    input  logic                            aresetn,
    adc_capture_buf_if.slave                bus,
    input  logic                            arm,
    input  logic                            trig,
    input  logic                            abort,
    input  logic [BRAMTOHOST_ADDRWIDTH-1:0] nwords_m1,
    input  logic [7:0]                      decim,
    output logic                            busy,
    output logic                            done,
    output logic [BRAMTOHOST_ADDRWIDTH:0]   wcount
);
    localparam int unsigned DW  = ADC_AXIS_DATAWIDTH;
    localparam int unsigned AW  = BRAMTOHOST_ADDRWIDTH;
    localparam int unsigned WCW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_nwords_m1;
    logic [WCW-1:0]  r_wcount;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic            r_we, r_tready, r_busy, r_done;
    logic            w_cand, w_keep, w_last, w_load, w_dcnt_zero;

`ifdef ADC_CAPTURE_DECIM_EN
    localparam int unsigned DCW = 8;
    logic [DCW-1:0] r_decim, r_dcnt, w_dcnt_base;

    // The trigger cycle starts a fresh decimation phase.
    assign w_dcnt_base = (r_state == S_ARMED) ? '0 : r_dcnt;
    assign w_dcnt_zero = (w_dcnt_base == '0);

    always_ff @(posedge dspclk or negedge aresetn) begin
        if (!aresetn) begin
            r_decim <= '0;
            r_dcnt  <= '0;
        end else if (w_load) begin
            r_decim <= decim;
            r_dcnt  <= '0;
        end else if (w_cand && bus.s_tvalid) begin
            r_dcnt <= (w_dcnt_base == r_decim) ? '0 : w_dcnt_base + DCW'(1);
        end
    end
`else
    logic w_unused_decim;
    assign w_unused_decim = ^decim;
    assign w_dcnt_zero    = 1'b1;
`endif

    always_ff @(posedge dspclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Candidate beats: the trigger cycle in ARMED, then every cycle in CAPTURE.
    always_comb begin
        w_state_nxt = r_state;
        w_cand      = ~abort & (((r_state == S_ARMED) & trig) | (r_state == S_CAPTURE));
        w_keep      = w_cand & bus.s_tvalid & w_dcnt_zero;
        w_last      = w_keep & (r_wcount[AW-1:0] == r_nwords_m1);
        w_load      = ~abort & arm & ((r_state == S_IDLE) | (r_state == S_DONE));
        case (r_state)
            S_IDLE, S_DONE: if (w_load) w_state_nxt = S_ARMED;
            S_ARMED:        if (w_cand) w_state_nxt = w_last ? S_DONE : S_CAPTURE;
            S_CAPTURE:      if (w_last) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge dspclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tready    <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wcount    <= '0;
            r_nwords_m1 <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            r_we     <= w_keep;
            r_busy   <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
            r_done   <= (w_state_nxt == S_DONE);
            if (w_load) begin
                r_wcount    <= '0;
                r_nwords_m1 <= nwords_m1;
            end
            if (w_keep) begin
                r_addr   <= r_wcount[AW-1:0];
                r_data   <= bus.s_tdata;
                r_wcount <= r_wcount + WCW'(1);
            end
        end
    end

    assign bus.s_tready  = r_tready;
    assign bus.bram_we   = r_we;
    assign bus.bram_addr = r_addr;
    assign bus.bram_data = r_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign wcount        = r_wcount;
endmodule
